// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction ROM
// and registers each fetched word into the IF/ID boundary behind a valid/ready handshake.
module fetch_stage #(
  parameter int              N              = 32,
  parameter int              PC_W           = 64,
  parameter int              ADDR_W         = 6,
  parameter logic [PC_W-1:0] RESET_PC       = '0,
  parameter int              HALT_ON_EBREAK = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [N-1:0]      imem_q,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              resume,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_fault,
  output logic              halted
);

  localparam logic [N-1:0] NOP_WORD    = N'(32'h0000_0013);
  localparam logic [N-1:0] EBREAK_WORD = N'(32'h0010_0073);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            out_valid_q, out_valid_d;
  logic [N-1:0]    out_instr_q, out_instr_d;
  logic [PC_W-1:0] out_pc_q, out_pc_d;
  logic            out_fault_q, out_fault_d;
  logic            halted_q, halted_d;

  logic            fault;
  logic [N-1:0]    fetch_word;
  logic            adv;
  logic            is_ebreak;

  // Misaligned or outside the ROM window: no aliasing of high PC bits onto the ROM.
  assign fault      = (pc_q[1:0] != 2'b00) || (pc_q[PC_W-1:ADDR_W+2] != '0);
  assign imem_addr  = pc_q[ADDR_W+1:2];
  assign fetch_word = fault ? NOP_WORD : imem_q;
  assign adv        = !out_valid_q || out_ready;
  assign is_ebreak  = (HALT_ON_EBREAK != 0) && !fault && (imem_q == EBREAK_WORD);

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path leaves it unassigned (no latch).
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    out_fault_d = out_fault_q;
    halted_d    = halted_q;

    if (redirect_valid) begin
      pc_d        = redirect_pc;
      out_valid_d = 1'b0;
      halted_d    = 1'b0;
    end else if (halted_q) begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      if (resume)                   halted_d    = 1'b0;
    end else if (adv) begin
      out_instr_d = fetch_word;
      out_pc_d    = pc_q;
      out_fault_d = fault;
      out_valid_d = 1'b1;
      pc_d        = pc_q + PC_W'(4);
      if (is_ebreak) halted_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      out_fault_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      out_fault_q <= out_fault_d;
      halted_q    <= halted_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign out_fault = out_fault_q;
  assign halted    = halted_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the program counter and drives the word address of the combinational instruction ROM (64 x 32-bit, 6-bit word address). Registers the fetched word and its PC into the IF/ID boundary with a valid/ready handshake.
- Supports control-flow redirect from execute, fetch-fault tagging, and halt-on-EBREAK with an external resume.

Parameters:
- N, 32, instruction width (matches ROM word width).
- PC_W, 64, program counter width (RV64).
- ADDR_W, 6, ROM word-address width (ROM depth = 2**ADDR_W).
- RESET_PC, 64'h0, PC value loaded on reset.
- HALT_ON_EBREAK, 1, 1 = stop fetching after delivering an EBREAK; 0 = treat EBREAK as an ordinary instruction.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  ADDR_W  ROM word address = pc[ADDR_W+1:2]; combinational from the PC register.
- imem_q  in  N  ROM read data; valid in the same cycle as imem_addr.
- redirect_valid  in  1  taken branch/jump from execute; one-cycle pulse.
- redirect_pc  in  PC_W  redirect target.
- resume  in  1  leave the halted state; level, sampled each cycle.
- out_valid  out  1  IF/ID register holds a valid instruction.
- out_ready  in  1  decode accepts the IF/ID contents this cycle.
- out_instr  out  N  fetched instruction.
- out_pc  out  PC_W  PC of out_instr.
- out_fault  out  1  out_instr is a substituted NOP due to a fetch fault.
- halted  out  1  fetch stopped after EBREAK.

Behaviour:
- Reset values (any cycle reset=1, including mid-handshake or while halted):
  - pc = RESET_PC
  - out_valid = 0, out_instr = 0, out_pc = 0, out_fault = 0
  - halted = 0
- Fault check, combinational on the current pc:
  - fault when pc[1:0] != 0, or when pc[PC_W-1:ADDR_W+2] != 0 (outside ROM range).
  - No aliasing is permitted: an out-of-range PC faults.
- Fetched word: fetch_word = fault ? 32'h00000013 (NOP) : imem_q.
- Advance condition: adv = !out_valid || out_ready.
- Per-cycle update, in priority order:
  1. reset: apply reset values.
  2. redirect_valid:
     - pc <= redirect_pc
     - out_valid <= 0, which flushes the IF/ID entry even if it is being accepted this cycle.
     - halted <= 0
     - No fetch this cycle. First instruction from the target appears in IF/ID one cycle later (redirect in cycle t, out_valid with out_pc=redirect_pc at t+2).
  3. halted:
     - No fetch; pc holds.
     - If out_valid && out_ready, then out_valid <= 0.
     - If resume, halted <= 0; fetch restarts the next cycle from the held pc, which is the address after the EBREAK.
  4. adv:
     - out_instr <= fetch_word, out_pc <= pc, out_fault <= fault, out_valid <= 1.
     - pc <= pc + 4, modulo 2**PC_W.
     - If HALT_ON_EBREAK and !fault and imem_q == 32'h00100073, then halted <= 1. The EBREAK itself is delivered to decode.
  5. Otherwise (out_valid && !out_ready) it is a stall:
     - All outputs and pc hold.
     - out_instr/out_pc/out_fault must stay stable while out_valid=1 and out_ready=0.
- Throughput and latency:
  - One instruction per cycle when out_ready is held high.
  - Fetch-to-IF/ID latency is 1 cycle.
- Faults:
  - A faulted fetch still advances pc by 4. No recovery is done here; recovery is by redirect or reset.
- Simultaneous events:
  - reset beats redirect, which beats halt/resume, which beats fetch.
  - resume while not halted has no effect.
  - A redirect while halted both clears halt and redirects.

Test Plan:
- Reset then out_ready=1 for 3 cycles -> out_pc 0,4,8 with out_instr 0xff010113, 0x00113423, 0x00813023; out_fault=0; imem_addr 0,1,2,3.
- Backpressure: out_ready=0 for 4 cycles while at out_pc=4 -> out_instr held at 0x00113423, pc held at 8. Release -> next out_pc=8.
- Redirect: pulse redirect_valid with redirect_pc=0x98 while IF/ID is valid -> out_valid=0 the next cycle, then out_pc=0x98, out_instr=0xfd010113; the flushed entry is never accepted.
- EBREAK: run from 0xa8 -> entry at out_pc=0xb8 (0x00100073) is delivered and halted=1; no further fetch for 5 cycles. resume=1 for 1 cycle -> next entry out_pc=0xbc, out_instr=0xfe043583, halted=0.
- Faults:
  - redirect_pc=0x9a -> out_fault=1, out_instr=0x00000013, next out_pc=0x9e.
  - redirect_pc=0x100 -> fault with NOP.
  - HALT_ON_EBREAK=0 at 0xb8 -> no halt.
- Priority: reset and redirect_valid together -> pc=RESET_PC, out_valid=0. Reset asserted while halted with out_valid=1 -> all outputs return to their reset values.
